// File: rtl/bp_pkg.sv
// Shared constants and arithmetic helpers for the branch predictor.
// Latency: n/a (package only).
// Backpressure: n/a.
// Helpers work on 32-bit values; callers zero-extend their operands and take
// the low bits of the result. Widths up to 32 bits are supported.
package bp_pkg;

  localparam int BP_STATIC_NT = 0;
  localparam int BP_STATIC_T  = 1;
  localparam int BP_BIMODAL   = 2;
  localparam int BP_GSHARE    = 3;

  // Weakly not-taken: 2^(bits-1)-1, e.g. 2'b01 for 2-bit counters.
  function automatic logic [31:0] ctr_reset_val(input int bits);
    return (32'd1 << (bits - 1)) - 32'd1;
  endfunction

  // Saturating up/down step of a bits-wide counter.
  function automatic logic [31:0] ctr_sat_update(input logic [31:0] val,
                                                 input logic        up,
                                                 input int          bits);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - bits);
    if (up) return (val == max_v) ? val : val + 32'd1;
    else    return (val == 32'd0) ? val : val - 32'd1;
  endfunction

  // Saturating increment for statistics; sticks at all-ones.
  function automatic logic [31:0] stat_sat_inc(input logic [31:0] val,
                                               input int          bits);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - bits);
    return (val == max_v) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of saturating counters: one combinational read port, one update port.
// Latency: read 0 cycles (no bypass of a same-cycle update); update lands at the edge.
// Backpressure: none; an update is accepted every cycle wr_valid is high.
// Ports: clk/rst (async active-low), rd_index -> rd_ctr,
//        wr_valid/wr_index/wr_taken train one entry per cycle.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [CTR_BITS-1:0]   rd_ctr,
  input  logic                  wr_valid,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic                  wr_taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [31:0] RST_FULL = ctr_reset_val(CTR_BITS);
  localparam logic [CTR_BITS-1:0] RST_VAL = RST_FULL[CTR_BITS-1:0];

  logic [CTR_BITS-1:0] table_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d;
  logic [31:0]         ctr_full;

  assign rd_ctr   = table_q[rd_index];
  assign ctr_full = ctr_sat_update(32'(table_q[wr_index]), wr_taken, CTR_BITS);
  assign ctr_d    = ctr_full[CTR_BITS-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= RST_VAL;
    end else if (wr_valid) begin
      table_q[wr_index] <= ctr_d;
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Configurable branch predictor (static NT/T, bimodal, gshare) with history recovery and stats.
// Latency: prediction/index combinational in ID; training, history and stats update at the edge.
// Backpressure: none; pred_stall only freezes the speculative history shift.
// Ports: pred_* predict the BEQ in ID; upd_* train from the branch resolved in MEM;
//        mispredict is combinational; stat_* count resolved branches and mispredicts.
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int PC_SHIFT   = 0,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 4,
  parameter int MODE       = 2,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_valid,
  input  logic                  pred_stall,
  input  logic [PC_WIDTH-1:0]   pred_pc,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_pred,
  input  logic                  upd_taken,
  output logic                  mispredict,
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts,
  output logic [GHR_BITS-1:0]   spec_ghr
);

  logic [GHR_BITS-1:0]   spec_ghr_q, spec_ghr_d;
  logic [GHR_BITS-1:0]   committed_ghr_q, committed_ghr_d;
  logic [GHR_BITS-1:0]   commit_shift, spec_shift;
  logic [STAT_WIDTH-1:0] stat_br_q, stat_br_d;
  logic [STAT_WIDTH-1:0] stat_mp_q, stat_mp_d;
  logic [31:0]           br_inc, mp_inc;
  logic [INDEX_BITS-1:0] pc_idx, ghr_ext;
  logic [CTR_BITS-1:0]   rd_ctr;
  logic                  unused_pc_bits;

  // Only a slice of the PC is used for indexing.
  assign unused_pc_bits = ^pred_pc;

  assign pc_idx = pred_pc[PC_SHIFT+INDEX_BITS-1:PC_SHIFT];

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_BITS-1:0] = spec_ghr_q;
  end

  assign pred_index = (MODE == BP_GSHARE) ? (pc_idx ^ ghr_ext) : pc_idx;

  bp_counter_table #(
    .INDEX_BITS (INDEX_BITS),
    .CTR_BITS   (CTR_BITS)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .rd_index (pred_index),
    .rd_ctr   (rd_ctr),
    .wr_valid (upd_valid),
    .wr_index (upd_index),
    .wr_taken (upd_taken)
  );

  always_comb begin
    pred_taken = 1'b0;
    case (MODE)
      BP_STATIC_T:            pred_taken = 1'b1;
      BP_BIMODAL, BP_GSHARE:  pred_taken = rd_ctr[CTR_BITS-1];
      default:                pred_taken = 1'b0;
    endcase
  end

  assign mispredict = upd_valid & (upd_pred ^ upd_taken);

  generate
    if (GHR_BITS == 1) begin : g_ghr1
      assign commit_shift = upd_taken;
      assign spec_shift   = pred_taken;
    end else begin : g_ghrn
      assign commit_shift = {committed_ghr_q[GHR_BITS-2:0], upd_taken};
      assign spec_shift   = {spec_ghr_q[GHR_BITS-2:0], pred_taken};
    end
  endgenerate

  // Recovery wins over a same-cycle prediction: that younger branch is flushed.
  always_comb begin
    spec_ghr_d = spec_ghr_q;
    if (mispredict)                    spec_ghr_d = commit_shift;
    else if (pred_valid && !pred_stall) spec_ghr_d = spec_shift;
  end

  assign committed_ghr_d = upd_valid ? commit_shift : committed_ghr_q;

  assign br_inc = stat_sat_inc(32'(stat_br_q), STAT_WIDTH);
  assign mp_inc = stat_sat_inc(32'(stat_mp_q), STAT_WIDTH);

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (stat_clear) begin
      stat_br_d = '0;
      stat_mp_d = '0;
    end else begin
      if (upd_valid)  stat_br_d = br_inc[STAT_WIDTH-1:0];
      if (mispredict) stat_mp_d = mp_inc[STAT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_ghr_q      <= '0;
      committed_ghr_q <= '0;
      stat_br_q       <= '0;
      stat_mp_q       <= '0;
    end else begin
      spec_ghr_q      <= spec_ghr_d;
      committed_ghr_q <= committed_ghr_d;
      stat_br_q       <= stat_br_d;
      stat_mp_q       <= stat_mp_d;
    end
  end

  assign spec_ghr         = spec_ghr_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench: bimodal instance and gshare instance share all inputs.
// Latency: n/a.
// Backpressure: n/a.
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_stall, upd_valid, upd_pred, upd_taken, stat_clear;
  logic [31:0] pred_pc;
  logic [5:0]  upd_index;

  logic       bi_pred_taken, bi_mispredict;
  logic [5:0] bi_pred_index;
  logic [3:0] bi_stat_br, bi_stat_mp, bi_spec_ghr;

  logic       gs_pred_taken, gs_mispredict;
  logic [5:0] gs_pred_index;
  logic [3:0] gs_stat_br, gs_stat_mp, gs_spec_ghr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gshare_branch_predictor #(.MODE(2), .STAT_WIDTH(4)) u_bi (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_stall(pred_stall), .pred_pc(pred_pc),
    .pred_taken(bi_pred_taken), .pred_index(bi_pred_index),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_pred(upd_pred), .upd_taken(upd_taken),
    .mispredict(bi_mispredict), .stat_clear(stat_clear),
    .stat_branches(bi_stat_br), .stat_mispredicts(bi_stat_mp), .spec_ghr(bi_spec_ghr)
  );

  gshare_branch_predictor #(.MODE(3), .STAT_WIDTH(4)) u_gs (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_stall(pred_stall), .pred_pc(pred_pc),
    .pred_taken(gs_pred_taken), .pred_index(gs_pred_index),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_pred(upd_pred), .upd_taken(upd_taken),
    .mispredict(gs_mispredict), .stat_clear(stat_clear),
    .stat_branches(gs_stat_br), .stat_mispredicts(gs_stat_mp), .spec_ghr(gs_spec_ghr)
  );

  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [5:0]  ui;
    logic        up;
    logic        ut;
    logic        e_pre;
    logic        e_mis;
    logic        e_post;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1: leaves the cycle at posedge+1 of the next cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One gshare prediction: check the prediction, then let history shift.
  task automatic gs_predict(input logic [31:0] pc, input logic exp);
    pred_valid = 1'b1;
    pred_pc    = pc;
    #1;
    check("gs_pred_taken", 32'(gs_pred_taken), 32'(exp));
    next_cycle();
    pred_valid = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    next_cycle();
  endtask

  initial begin
    // Bimodal training vectors at index 5 (counter starts at 01).
    vecs[0]  = '{32'h05, 1'b1, 6'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // 1->2, pre sees old value
    vecs[1]  = '{32'h05, 1'b1, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // 2->3
    vecs[2]  = '{32'h05, 1'b1, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // sat 3
    vecs[3]  = '{32'h05, 1'b1, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{32'h05, 1'b1, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{32'h05, 1'b1, 6'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}; // 3->2
    vecs[6]  = '{32'h05, 1'b1, 6'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}; // 2->1
    vecs[7]  = '{32'h04, 1'b1, 6'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // idx4 1->2
    vecs[8]  = '{32'h05, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // 1->0
    vecs[9]  = '{32'h05, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // sat 0
    vecs[10] = '{32'h05, 1'b1, 6'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}; // 0->1
    vecs[11] = '{32'h44, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // pc 0x44 -> idx 4

    rst = 1'b0; pred_valid = 1'b0; pred_stall = 1'b0; pred_pc = 32'h7;
    upd_valid = 1'b0; upd_index = '0; upd_pred = 1'b0; upd_taken = 1'b0; stat_clear = 1'b0;

    // Reset state
    #2;
    check("reset_pred_taken", 32'(bi_pred_taken), 32'd0);
    check("reset_pred_index", 32'(bi_pred_index), 32'h7);
    check("reset_spec_ghr",   32'(bi_spec_ghr),   32'd0);
    check("reset_stat_br",    32'(bi_stat_br),    32'd0);
    check("reset_stat_mp",    32'(bi_stat_mp),    32'd0);
    check("reset_gs_pred",    32'(gs_pred_taken), 32'd0);
    #10 rst = 1'b1;
    next_cycle();

    // Bimodal training table
    for (int i = 0; i < 12; i++) begin
      pred_pc   = vecs[i].pc;
      upd_valid = vecs[i].uv;
      upd_index = vecs[i].ui;
      upd_pred  = vecs[i].up;
      upd_taken = vecs[i].ut;
      #1;
      check($sformatf("bi_pre[%0d]", i),  32'(bi_pred_taken), 32'(vecs[i].e_pre));
      check($sformatf("bi_misp[%0d]", i), 32'(bi_mispredict), 32'(vecs[i].e_mis));
      next_cycle();
      upd_valid = 1'b0;
      #1;
      check($sformatf("bi_post[%0d]", i), 32'(bi_pred_taken), 32'(vecs[i].e_post));
    end
    check("bi_stat_br_11", 32'(bi_stat_br), 32'd11);
    check("bi_stat_mp_5",  32'(bi_stat_mp), 32'd5);

    // Asynchronous reset mid-cycle, with pc 0x44 currently predicted taken
    #2 rst = 1'b0;
    #1;
    check("async_rst_pred",   32'(bi_pred_taken), 32'd0);
    check("async_rst_stat_br", 32'(bi_stat_br),   32'd0);
    check("async_rst_stat_mp", 32'(bi_stat_mp),   32'd0);
    check("async_rst_ghr",    32'(bi_spec_ghr),   32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    next_cycle();

    // Gshare: train idx 0x2A to 11 with correct predictions; committed -> 0011
    for (int i = 0; i < 2; i++) begin
      upd_valid = 1'b1; upd_index = 6'h2A; upd_pred = 1'b1; upd_taken = 1'b1;
      #1;
      check("gs_train_no_misp", 32'(gs_mispredict), 32'd0);
      next_cycle();
    end
    upd_valid = 1'b0;
    check("gs_spec_after_train", 32'(gs_spec_ghr), 32'd0);

    // History 1,0,1,0 -> 1010
    gs_predict(32'h2A, 1'b1);
    gs_predict(32'h00, 1'b0);
    gs_predict(32'h28, 1'b1);
    gs_predict(32'h00, 1'b0);
    check("gs_spec_1010", 32'(gs_spec_ghr), 32'hA);
    pred_pc = 32'h13;
    #1;
    check("gs_hash_index", 32'(gs_pred_index), 32'h19);

    // Bring speculative history to 0111 (shift in 0,1,1,1)
    gs_predict(32'h00, 1'b0);
    gs_predict(32'h2E, 1'b1);
    gs_predict(32'h23, 1'b1);
    gs_predict(32'h29, 1'b1);
    check("gs_spec_0111", 32'(gs_spec_ghr), 32'h7);

    // Recovery: mispredict alongside a taken prediction
    pred_valid = 1'b1; pred_pc = 32'h2D;
    upd_valid = 1'b1; upd_index = 6'h3F; upd_pred = 1'b1; upd_taken = 1'b0;
    #1;
    check("gs_recov_pred", 32'(gs_pred_taken), 32'd1);
    check("gs_recov_misp", 32'(gs_mispredict), 32'd1);
    next_cycle();
    pred_valid = 1'b0; upd_valid = 1'b0;
    #1;
    check("gs_recov_spec", 32'(gs_spec_ghr), 32'h6);
    check("gs_recov_stat_mp", 32'(gs_stat_mp), 32'd1);
    check("gs_recov_stat_br", 32'(gs_stat_br), 32'd3);

    // Second mispredict exposes committed history 0110 -> 1101
    upd_valid = 1'b1; upd_index = 6'h3F; upd_pred = 1'b0; upd_taken = 1'b1;
    next_cycle();
    upd_valid = 1'b0;
    #1;
    check("gs_committed_1101", 32'(gs_spec_ghr), 32'hD);

    // Stall: history and table frozen
    pred_valid = 1'b1; pred_stall = 1'b1; pred_pc = 32'h27;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_pred[%0d]", i), 32'(gs_pred_taken), 32'd1);
      next_cycle();
      #1;
      check($sformatf("stall_ghr[%0d]", i), 32'(gs_spec_ghr), 32'hD);
    end
    pred_stall = 1'b0;
    next_cycle();
    pred_valid = 1'b0;
    #1;
    check("unstall_ghr", 32'(gs_spec_ghr), 32'hB);

    // Statistics saturation and clear priority
    do_reset();
    for (int i = 0; i < 20; i++) begin
      upd_valid = 1'b1; upd_index = 6'd0; upd_pred = 1'b0; upd_taken = 1'b1;
      next_cycle();
    end
    upd_valid = 1'b0;
    #1;
    check("stat_br_sat", 32'(bi_stat_br), 32'd15);
    check("stat_mp_sat", 32'(bi_stat_mp), 32'd15);
    upd_valid = 1'b1; stat_clear = 1'b1;
    next_cycle();
    upd_valid = 1'b0; stat_clear = 1'b0;
    #1;
    check("stat_clear_br", 32'(bi_stat_br), 32'd0);
    check("stat_clear_mp", 32'(bi_stat_mp), 32'd0);
    upd_valid = 1'b1;
    next_cycle();
    upd_valid = 1'b0;
    #1;
    check("stat_after_clear_br", 32'(bi_stat_br), 32'd1);
    check("stat_after_clear_mp", 32'(bi_stat_mp), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
